// File: rtl/hazard_scoreboard_id_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard_id_pkg
//  Description : Shared constants for the ID-stage hazard scoreboard:
//                the hard-wired zero register, the standard result
//                latencies and default sizing of the countdown counters.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_scoreboard_id_pkg;

    localparam logic [4:0] REG_ZERO    = 5'd0;
    localparam int         LAT_ALU     = 0;
    localparam int         LAT_LW      = 1;
    localparam int         DEF_MAX_LAT = 7;
    localparam int         DEF_LAT_W   = 3;

endpackage : hazard_scoreboard_id_pkg
`default_nettype wire

// File: rtl/hazard_scoreboard_id_sb_entry.sv
`default_nettype none
// ============================================================================
//  Module      : sb_entry
//  Description : One scoreboard entry: a countdown of the cycles until a
//                pending register write can be consumed from the bypass
//                network.
//  Ports       : i_clock     rising-edge clock
//                i_reset     asynchronous active-high reset
//                i_load      start a new countdown with i_load_val
//                i_load_val  cycles still to wait
//                i_hold      freeze the counter (pipeline frozen)
//                o_busy      counter is nonzero
//                o_cnt       current count
//  Revision    : 1.0 - initial release
// ============================================================================
module sb_entry
    import hazard_scoreboard_id_pkg::*;
#(
    parameter int LAT_W = DEF_LAT_W
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [LAT_W-1:0] i_load_val,
    input  logic             i_hold,
    output logic             o_busy,
    output logic [LAT_W-1:0] o_cnt
);

    logic [LAT_W-1:0] r_cnt;

    // A load replaces the decrement that would otherwise happen this cycle.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (!i_hold) begin
            if (i_load) begin
                r_cnt <= i_load_val;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - LAT_W'(1);
            end
        end
    end

    assign o_busy = (r_cnt != '0);
    assign o_cnt  = r_cnt;

endmodule : sb_entry
`default_nettype wire

// File: rtl/hazard_scoreboard_id.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard_id
//  Description : ID-stage load-use hazard unit with per-register pending
//                write countdowns. An instruction stalls in ID while any
//                source it reads is still counting down, or while an older
//                write to its destination would finish after its own.
//                Drives PC / IF-ID write enables and the ID/EX bubble.
//  Option      : HAZARD_STATS_EN adds i_stats_clr and o_stall_cycles
//                (saturating count of non-frozen stall cycles).
//  Ports       : i_clock, i_reset (async, active-high)
//                i_id_valid, i_id_rs, i_id_rt, i_id_uses_rt, i_id_rd,
//                i_id_regwrite, i_id_lat   - decoded ID-stage instruction
//                i_flush                   - kill the instruction in ID
//                i_mem_hold                - whole-pipeline freeze
//                o_stall, o_pc_write, o_ifid_write, o_bubble, o_busy_mask
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard_id
    import hazard_scoreboard_id_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int NUM_REGS = 32,
    parameter int MAX_LAT  = DEF_MAX_LAT,
    parameter int LAT_W    = DEF_LAT_W
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_id_valid,
    input  logic [REG_AW-1:0]   i_id_rs,
    input  logic [REG_AW-1:0]   i_id_rt,
    input  logic                i_id_uses_rt,
    input  logic [REG_AW-1:0]   i_id_rd,
    input  logic                i_id_regwrite,
    input  logic [LAT_W-1:0]    i_id_lat,
    input  logic                i_flush,
    input  logic                i_mem_hold,
    output logic                o_stall,
    output logic                o_pc_write,
    output logic                o_ifid_write,
    output logic                o_bubble,
    output logic [NUM_REGS-1:0] o_busy_mask
`ifdef HAZARD_STATS_EN
    ,
    input  logic                i_stats_clr,
    output logic [31:0]         o_stall_cycles
`endif
);

    localparam int               c_NUM_SLOTS = 1 << REG_AW;
    localparam logic [LAT_W-1:0] c_MAX_LAT   = LAT_W'(MAX_LAT);
    localparam logic [REG_AW-1:0] c_REG_ZERO = REG_AW'(REG_ZERO);

    // Counters padded to the full address space so any register address
    // indexes safely; untracked slots read as zero.
    logic [LAT_W-1:0] w_cnt [0:c_NUM_SLOTS-1];
    logic [LAT_W-1:0] w_lat;
    logic             w_hz_rs;
    logic             w_hz_rt;
    logic             w_hz_waw;
    logic             w_issue;
    logic             w_issue_wr;

    assign w_lat = (int'(i_id_lat) > MAX_LAT) ? c_MAX_LAT : i_id_lat;

    assign w_hz_rs  = (i_id_rs != c_REG_ZERO) && (w_cnt[i_id_rs] != '0);
    assign w_hz_rt  = i_id_uses_rt && (i_id_rt != c_REG_ZERO) && (w_cnt[i_id_rt] != '0);
    // An older write finishing later than ours would clobber our result.
    assign w_hz_waw = i_id_regwrite && (i_id_rd != c_REG_ZERO) && (w_cnt[i_id_rd] > w_lat);

    assign o_stall      = i_id_valid && !i_flush && (w_hz_rs || w_hz_rt || w_hz_waw);
    assign w_issue      = i_id_valid && !i_flush && !o_stall && !i_mem_hold;
    assign w_issue_wr   = w_issue && i_id_regwrite && (i_id_rd != c_REG_ZERO);
    assign o_pc_write   = !o_stall && !i_mem_hold;
    assign o_ifid_write = !o_stall && !i_mem_hold;
    // Under a freeze ID/EX holds its contents rather than taking a NOP.
    assign o_bubble     = (o_stall || i_flush) && !i_mem_hold;

    assign o_busy_mask[0] = 1'b0;

    for (genvar r = 0; r < c_NUM_SLOTS; r++) begin : g_entry
        if (r >= 1 && r < NUM_REGS) begin : g_trk
            sb_entry #(
                .LAT_W      (LAT_W)
            ) u_entry (
                .i_clock    (i_clock),
                .i_reset    (i_reset),
                .i_load     (w_issue_wr && (i_id_rd == REG_AW'(r))),
                .i_load_val (w_lat),
                .i_hold     (i_mem_hold),
                .o_busy     (o_busy_mask[r]),
                .o_cnt      (w_cnt[r])
            );
        end else begin : g_idle
            assign w_cnt[r] = '0;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_stall_cycles <= '0;
        end else if (i_stats_clr) begin
            r_stall_cycles <= '0;
        end else if (o_stall && !i_mem_hold && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign o_stall_cycles = r_stall_cycles;
`else
    // Statistics disabled: no counter, no extra ports.
`endif

endmodule : hazard_scoreboard_id
`default_nettype wire

// File: tb/tb_hazard_scoreboard_id.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_scoreboard_id
//  Description : Directed self-checking bench for hazard_scoreboard_id.
//                Inputs change on the falling edge; outputs are sampled
//                1 ns later, well before the next rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard_id;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, uses_rt, regwrite, flush, mem_hold;
    logic [4:0]  rs, rt, rd;
    logic [2:0]  lat;
    logic        stall, pc_write, ifid_write, bubble;
    logic [31:0] busy;
    logic        stats_clr = 1'b0;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles;
`endif

    int checks = 0;
    int fails  = 0;
    int n;

    always #5 clk = ~clk;

    hazard_scoreboard_id dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_id_valid    (valid),
        .i_id_rs       (rs),
        .i_id_rt       (rt),
        .i_id_uses_rt  (uses_rt),
        .i_id_rd       (rd),
        .i_id_regwrite (regwrite),
        .i_id_lat      (lat),
        .i_flush       (flush),
        .i_mem_hold    (mem_hold),
        .o_stall       (stall),
        .o_pc_write    (pc_write),
        .o_ifid_write  (ifid_write),
        .o_bubble      (bubble),
        .o_busy_mask   (busy)
`ifdef HAZARD_STATS_EN
        ,
        .i_stats_clr   (stats_clr),
        .o_stall_cycles(stall_cycles)
`endif
    );

    task automatic idle();
        valid = 0; rs = 0; rt = 0; uses_rt = 0; rd = 0;
        regwrite = 0; lat = 0; flush = 0; mem_hold = 0;
    endtask

    task automatic drive(input logic [4:0] prs, input logic [4:0] prt, input logic puse,
                         input logic [4:0] prd, input logic pwr, input logic [2:0] plat);
        valid = 1; rs = prs; rt = prt; uses_rt = puse; rd = prd;
        regwrite = pwr; lat = plat; flush = 0; mem_hold = 0;
    endtask

    // Holds the current ID instruction until it issues; returns stall cycles
    // (20 means it never issued).
    task automatic run_until_issue(output int cnt);
        cnt = 0;
        while (stall === 1'b1 && cnt < 20) begin
            cnt++;
            @(negedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1; idle();
        repeat (2) @(negedge clk);
        rst = 0; #1;
        checks++; if (stall !== 1'b0) begin fails++; $display("FAIL rst_stall: got %b want 0", stall); end
        checks++; if (bubble !== 1'b0) begin fails++; $display("FAIL rst_bubble: got %b want 0", bubble); end
        checks++; if (busy !== 32'h0) begin fails++; $display("FAIL rst_busy: got %h want 0", busy); end
        checks++; if (pc_write !== 1'b1) begin fails++; $display("FAIL rst_pc_write: got %b want 1", pc_write); end
        checks++; if (ifid_write !== 1'b1) begin fails++; $display("FAIL rst_ifid_write: got %b want 1", ifid_write); end
`ifdef HAZARD_STATS_EN
        checks++; if (stall_cycles !== 32'd0) begin fails++; $display("FAIL rst_stats: got %0d want 0", stall_cycles); end
`endif
    endtask

    task automatic test_load_use();
        @(negedge clk); drive(0, 0, 0, 8, 1, 1); #1;
        checks++; if (stall !== 1'b0) begin fails++; $display("FAIL lu_lw_stall: got %b want 0", stall); end
        @(negedge clk); drive(8, 0, 0, 10, 1, 0); #1;
        checks++; if (stall !== 1'b1) begin fails++; $display("FAIL lu_stall: got %b want 1", stall); end
        checks++; if (bubble !== 1'b1) begin fails++; $display("FAIL lu_bubble: got %b want 1", bubble); end
        checks++; if (pc_write !== 1'b0) begin fails++; $display("FAIL lu_pc_write: got %b want 0", pc_write); end
        checks++; if (ifid_write !== 1'b0) begin fails++; $display("FAIL lu_ifid_write: got %b want 0", ifid_write); end
        checks++; if (busy !== 32'h0000_0100) begin fails++; $display("FAIL lu_busy: got %h want 00000100", busy); end
        @(negedge clk); #1;
        checks++; if (stall !== 1'b0) begin fails++; $display("FAIL lu_release_stall: got %b want 0", stall); end
        checks++; if (bubble !== 1'b0) begin fails++; $display("FAIL lu_release_bubble: got %b want 0", bubble); end
        checks++; if (pc_write !== 1'b1) begin fails++; $display("FAIL lu_release_pc: got %b want 1", pc_write); end
        checks++; if (busy !== 32'h0) begin fails++; $display("FAIL lu_release_busy: got %h want 0", busy); end
        @(negedge clk); idle();
    endtask

    task automatic test_long_latency();
        @(negedge clk); drive(0, 0, 0, 5, 1, 3);
        @(negedge clk); drive(0, 5, 1, 11, 1, 0); #1;
        run_until_issue(n);
        checks++; if (n !== 3) begin fails++; $display("FAIL ll_rt_stalls: got %0d want 3", n); end
        @(negedge clk); drive(0, 0, 0, 5, 1, 3);
        @(negedge clk); drive(0, 5, 0, 11, 1, 0); #1;
        run_until_issue(n);
        checks++; if (n !== 0) begin fails++; $display("FAIL ll_no_rt_stalls: got %0d want 0", n); end
        @(negedge clk); idle();
        repeat (4) @(negedge clk);
        #1;
        checks++; if (busy !== 32'h0) begin fails++; $display("FAIL ll_drain_busy: got %h want 0", busy); end
    endtask

    task automatic test_reg0_lat0();
        @(negedge clk); drive(0, 0, 0, 0, 1, 3);
        @(negedge clk); drive(0, 0, 1, 12, 0, 0); #1;
        checks++; if (stall !== 1'b0) begin fails++; $display("FAIL r0_stall: got %b want 0", stall); end
        checks++; if (busy !== 32'h0) begin fails++; $display("FAIL r0_busy: got %h want 0", busy); end
        @(negedge clk); drive(0, 0, 0, 9, 1, 0);
        @(negedge clk); drive(9, 0, 0, 0, 0, 0); #1;
        checks++; if (stall !== 1'b0) begin fails++; $display("FAIL lat0_stall: got %b want 0", stall); end
        checks++; if (busy !== 32'h0) begin fails++; $display("FAIL lat0_busy: got %h want 0", busy); end
        @(negedge clk); idle();
    endtask

    task automatic test_waw();
        @(negedge clk); drive(0, 0, 0, 3, 1, 4);
        @(negedge clk); drive(0, 0, 0, 3, 1, 1); #1;
        run_until_issue(n);
        checks++; if (n !== 3) begin fails++; $display("FAIL waw_stalls: got %0d want 3", n); end
        @(negedge clk); idle(); #1;
        checks++; if (busy !== 32'h0000_0008) begin fails++; $display("FAIL waw_reload_busy: got %h want 00000008", busy); end
        @(negedge clk); #1;
        checks++; if (busy !== 32'h0) begin fails++; $display("FAIL waw_done_busy: got %h want 0", busy); end
    endtask

    task automatic test_mem_hold();
        @(negedge clk); drive(0, 0, 0, 7, 1, 3);
        @(negedge clk); drive(7, 0, 0, 13, 1, 0); #1;
        checks++; if (bubble !== 1'b1) begin fails++; $display("FAIL mh_c1_bubble: got %b want 1", bubble); end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); mem_hold = 1; #1;
            checks++; if (stall !== 1'b1) begin fails++; $display("FAIL mh_hold_stall: got %b want 1", stall); end
            checks++; if (bubble !== 1'b0) begin fails++; $display("FAIL mh_hold_bubble: got %b want 0", bubble); end
            checks++; if (pc_write !== 1'b0) begin fails++; $display("FAIL mh_hold_pc: got %b want 0", pc_write); end
        end
        @(negedge clk); mem_hold = 0; #1;
        checks++; if (stall !== 1'b1) begin fails++; $display("FAIL mh_c4_stall: got %b want 1", stall); end
        @(negedge clk); #1;
        checks++; if (stall !== 1'b1) begin fails++; $display("FAIL mh_c5_stall: got %b want 1", stall); end
        checks++; if (busy !== 32'h0000_0080) begin fails++; $display("FAIL mh_c5_busy: got %h want 00000080", busy); end
        @(negedge clk); #1;
        checks++; if (stall !== 1'b0) begin fails++; $display("FAIL mh_c6_stall: got %b want 0", stall); end
        checks++; if (pc_write !== 1'b1) begin fails++; $display("FAIL mh_c6_pc: got %b want 1", pc_write); end
        @(negedge clk); idle();
    endtask

    task automatic test_stats();
`ifdef HAZARD_STATS_EN
        @(negedge clk); stats_clr = 1;
        @(negedge clk); stats_clr = 0; #1;
        checks++; if (stall_cycles !== 32'd0) begin fails++; $display("FAIL st_clr: got %0d want 0", stall_cycles); end
        @(negedge clk); drive(0, 0, 0, 8, 1, 1);
        @(negedge clk); drive(8, 0, 0, 10, 1, 0);
        @(negedge clk); #1;
        checks++; if (stall_cycles !== 32'd1) begin fails++; $display("FAIL st_count: got %0d want 1", stall_cycles); end
        drive(0, 0, 0, 8, 1, 1);
        @(negedge clk); drive(8, 0, 0, 10, 1, 0); stats_clr = 1;
        @(negedge clk); stats_clr = 0; #1;
        checks++; if (stall_cycles !== 32'd0) begin fails++; $display("FAIL st_clr_wins: got %0d want 0", stall_cycles); end
        @(negedge clk); drive(0, 0, 0, 8, 1, 1);
        @(negedge clk); drive(8, 0, 0, 10, 1, 0);
        @(negedge clk); idle();
`endif
    endtask

    task automatic test_flush_reset();
        @(negedge clk); drive(0, 0, 0, 4, 1, 2);
        @(negedge clk); drive(4, 0, 0, 14, 1, 0); flush = 1; #1;
        checks++; if (stall !== 1'b0) begin fails++; $display("FAIL fl_stall: got %b want 0", stall); end
        checks++; if (bubble !== 1'b1) begin fails++; $display("FAIL fl_bubble: got %b want 1", bubble); end
        checks++; if (pc_write !== 1'b1) begin fails++; $display("FAIL fl_pc: got %b want 1", pc_write); end
        @(negedge clk); idle(); #1;
        checks++; if (busy !== 32'h0000_0010) begin fails++; $display("FAIL fl_decr_busy: got %h want 00000010", busy); end
        @(negedge clk); drive(0, 0, 0, 4, 1, 2);
        @(negedge clk); idle(); #1;
        checks++; if (busy !== 32'h0000_0010) begin fails++; $display("FAIL ar_pre_busy: got %h want 00000010", busy); end
`ifdef HAZARD_STATS_EN
        checks++; if (stall_cycles !== 32'd1) begin fails++; $display("FAIL ar_pre_stats: got %0d want 1", stall_cycles); end
`endif
        #2 rst = 1; #1;
        checks++; if (busy !== 32'h0) begin fails++; $display("FAIL ar_busy: got %h want 0", busy); end
`ifdef HAZARD_STATS_EN
        checks++; if (stall_cycles !== 32'd0) begin fails++; $display("FAIL ar_stats: got %0d want 0", stall_cycles); end
`endif
        @(negedge clk); rst = 0;
        @(negedge clk); drive(4, 0, 0, 0, 0, 0); #1;
        checks++; if (stall !== 1'b0) begin fails++; $display("FAIL ar_post_stall: got %b want 0", stall); end
        @(negedge clk); idle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_long_latency();
        test_reg0_lat0();
        test_waw();
        test_mem_hold();
        test_stats();
        test_flush_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule : tb_hazard_scoreboard_id
`default_nettype wire

// File: doc/hazard_scoreboard_id.md
Name: hazard_scoreboard_id

Overview:
- Parametrised load-use hazard unit in the ID stage of the pipelined MIPS core.
- Generalises single-cycle load-use detection to per-register pending-write countdowns with per-instruction result latency, so multi-cycle loads and multi-cycle ALU ops stall exactly as long as needed.
- Drives PC/IF-ID write enables and the ID/EX bubble select.
- Bypass selection stays in the EX-stage bypass logic.

Parameters:
- REG_AW, 5, register address width.
- NUM_REGS, 32, architectural registers tracked (register 0 never tracked).
- MAX_LAT, 7, largest accepted latency value.
- LAT_W, 3, counter width; must satisfy 2**LAT_W > MAX_LAT.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- id_valid  in  1  valid instruction in ID.
- id_rs  in  REG_AW  source A.
- id_rt  in  REG_AW  source B.
- id_uses_rt  in  1  rt is read (0 for addi/lw).
- id_rd  in  REG_AW  destination already muxed by RegDst.
- id_regwrite  in  1  instruction writes id_rd.
- id_lat  in  LAT_W  stall cycles a dependent in the next ID slot needs (lw=1, ALU=0).
- flush  in  1  kill instruction in ID (taken branch).
- mem_hold  in  1  whole-pipeline freeze from the memory system.
- stall  out  1  ID hazard detected.
- pc_write  out  1  active-high PC write enable.
- ifid_write  out  1  active-high IF/ID write enable.
- bubble  out  1  load NOP into ID/EX.
- busy_mask  out  NUM_REGS  bit r set when cnt[r]!=0; bit 0 always 0.

Behaviour:
- State: cnt[r], LAT_W bits, for r=1..NUM_REGS-1. Reset (asynchronous, any time, including mid-stall) clears all counters. Every output is combinational from state and inputs; after reset stall=0, bubble=0, busy_mask=0, pc_write=ifid_write=1 (given mem_hold=0).
- Hazard terms, all combinational:
  - hz_rs = id_rs!=0 & cnt[id_rs]!=0
  - hz_rt = id_uses_rt & id_rt!=0 & cnt[id_rt]!=0
  - hz_waw = id_regwrite & id_rd!=0 & cnt[id_rd] > id_lat
- stall = id_valid & ~flush & (hz_rs | hz_rt | hz_waw).
- issue = id_valid & ~flush & ~stall & ~mem_hold.
- pc_write = ifid_write = ~stall & ~mem_hold.
- bubble = (stall | flush) & ~mem_hold. Under mem_hold, ID/EX holds its contents and is not bubbled.
- Per cycle, if mem_hold=1: all counters hold and no issue occurs.
- Per cycle, if mem_hold=0:
  - If issue & id_regwrite & id_rd!=0, then cnt[id_rd] <= id_lat. This overrides that register's decrement in the same cycle.
  - Every other nonzero counter decrements by 1.
- Timing: lw (lat 1) followed by a dependent gives exactly one bubble. lat=L gives L bubbles. lat=0 gives no tracking.
- id_lat > MAX_LAT is clamped to MAX_LAT.
- Writes to register 0 are never tracked.
- flush with a hazard present gives stall=0 and bubble=1. Counters still decrement.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined: adds output stall_cycles (32 bits) and input stats_clr.
  - Counter increments on every clock with stall=1 & ~mem_hold, saturating at 32'hFFFFFFFF.
  - stats_clr zeroes it synchronously and wins over increment.
  - reset clears it.
- Undefined: no port and no counter; remaining behaviour identical.

Decomposition:
- Shared header constants: REG_ZERO (5'd0), LAT_ALU (0), LAT_LW (1), defaults for MAX_LAT and LAT_W.
- One sub-module, sb_entry: one countdown counter. Inputs: clock, reset, load, load_val, hold. Outputs: busy, cnt. Instantiated NUM_REGS-1 times by generate.
- Hazard compare and enable logic stay in the top module.

Test Plan:
- Load-use: issue lw rd=8 lat=1, then add rs=8 in ID -> stall=1, bubble=1, pc_write=0 for exactly 1 cycle, then issue; busy_mask[8] high for 1 cycle.
- Long latency: lat=3 to rd=5, dependent sub rt=5 (id_uses_rt=1) -> 3 stall cycles. Repeat with id_uses_rt=0 -> 0 stalls.
- Register 0 and lat=0:
  - lw rd=0 lat=3, then use of rs=0 -> no stall, busy_mask=0.
  - addi rd=9 lat=0, then use rs=9 -> no stall.
- WAW: lat=4 to rd=3, next instruction writes rd=3 lat=1 -> stalls until cnt[3]<=1, then cnt[3]=1.
- mem_hold mid-stall: lat=3 to rd=7, dependent in ID, hold for 2 cycles after first stall -> counter frozen, bubble=0 during hold, total 5 cycles before issue.
- Flush and reset: flush with hazard -> stall=0, bubble=1. Asynchronous reset pulse while cnt[4]=2 -> busy_mask=0 immediately; stall_cycles=0 under HAZARD_STATS_EN.
